alu_pipe: RTL and testbench

Parametrised, pipelined successor to the team's single-cycle 4-bit ALU.
- Generalises operand width and widens the product to 2*WIDTH.
- Adds status flags and a valid/ready handshake on both input and output with full backpressure.
- Sits between an operand-issue stage and a result-consuming stage. Drop-in datapath element for wider testbench DUTs.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_pipe_core.sv | 79 +++++++
 rtl/alu_pipe.sv | 77 +++++++
 tb/tb_alu_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, flag and width definitions for alu_pipe
package alu_pkg;

  localparam int FLAG_W = 4;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_MUL  = 3'b100,
    OP_XOR  = 3'b101,
    OP_NAND = 3'b110,
    OP_NOR  = 3'b111
  } alu_op_e;

  // Bit order matches the flags port: {neg, ovf, carry, zero}
  typedef struct packed {
    logic neg;
    logic ovf;
    logic carry;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/alu_pipe_core.sv
// rtl/alu_pipe_core.sv - combinational opcode and flag evaluation; ALU_PIPE_SAT_EN enables ADD/SUB saturation
module alu_pipe_core
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int RES_W = 2 * WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic [RES_W-1:0] result,
  output alu_flags_t       flags
);

  alu_op_e            op;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [RES_W-1:0]   prod;
  logic               ovf_add;
  logic               ovf_sub;
  logic [WIDTH-1:0]   narrow;
  logic [RES_W-1:0]   wide;
  logic               is_mul;
  logic               carry;
  logic               ovf;

  assign op   = alu_op_e'(sel);
  // One extra bit captures carry-out for ADD and borrow for SUB
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Signed overflow is judged on the raw wrapped value, before any saturation
  assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
  assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  // Opcode decode: narrow result, raw carry/borrow and overflow per operation
  always_comb begin
    narrow = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    is_mul = 1'b0;
    case (op)
      OP_ADD: begin
        narrow = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = ovf_add;
`ifdef ALU_PIPE_SAT_EN
        if (sum[WIDTH]) narrow = '1;
`endif
      end
      OP_SUB: begin
        narrow = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
        ovf    = ovf_sub;
`ifdef ALU_PIPE_SAT_EN
        if (diff[WIDTH]) narrow = '0;
`endif
      end
      OP_AND:  narrow = a & b;
      OP_OR:   narrow = a | b;
      OP_MUL:  is_mul = 1'b1;
      OP_XOR:  narrow = a ^ b;
      OP_NAND: narrow = ~(a & b);
      OP_NOR:  narrow = ~(a | b);
      default: narrow = '0;
    endcase
  end

  // MUL keeps the full product; everything else is zero-extended
  assign wide   = is_mul ? prod : {{WIDTH{1'b0}}, narrow};
  assign result = wide;

  assign flags.neg   = is_mul ? wide[RES_W-1] : wide[WIDTH-1];
  assign flags.ovf   = ovf;
  assign flags.carry = carry;
  assign flags.zero  = (wide == '0);

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready ALU pipeline; ALU_PIPE_SAT_EN selects saturating ADD/SUB in the core
module alu_pipe
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int RES_W = 2 * WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [2:0]        sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  result,
  output logic [FLAG_W-1:0] flags
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_sel;
  logic             s2_valid;
  logic             s1_adv;
  logic             s2_adv;
  logic [RES_W-1:0] core_result;
  alu_flags_t       core_flags;

  // Advance terms depend only on registered valids and out_ready, never on in_valid
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Stage 1: capture operands and opcode whenever the stage can move
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sel   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= a;
        s1_b   <= b;
        s1_sel <= sel;
      end
    end
  end

  alu_pipe_core #(.WIDTH(WIDTH)) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .sel    (s1_sel),
    .result (core_result),
    .flags  (core_flags)
  );

  // Stage 2: register result and flags; they hold while the consumer stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      result   <= '0;
      flags    <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result <= core_result;
        flags  <= core_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed and streaming checks for alu_pipe at WIDTH=4
module tb_alu_pipe;

  localparam int W = 4;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [3:0] flags;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] exp_q[$];
  logic [11:0] exp_beat;

  // Directed expectations that change with saturation; flags = {neg, ovf, carry, zero}
`ifdef ALU_PIPE_SAT_EN
  localparam logic [7:0] ADD98_R = 8'h0F;
  localparam logic [3:0] ADD98_F = 4'b1110;
  localparam logic [7:0] SUB35_R = 8'h00;
  localparam logic [3:0] SUB35_F = 4'b0011;
`else
  localparam logic [7:0] ADD98_R = 8'h01;
  localparam logic [3:0] ADD98_F = 4'b0110;
  localparam logic [7:0] SUB35_R = 8'h0E;
  localparam logic [3:0] SUB35_F = 4'b1010;
`endif

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] va, input logic [3:0] vb, input logic [2:0] s);
    in_valid = v;
    a        = va;
    b        = vb;
    sel      = s;
  endtask

  // Single isolated beat: checks the 2-cycle latency, value, and that only one beat emerges
  task automatic one_beat(input string tag, input logic [3:0] va, input logic [3:0] vb,
                          input logic [2:0] s, input logic [7:0] er, input logic [3:0] ef);
    drive(1'b1, va, vb, s);
    step();
    drive(1'b0, 4'h0, 4'h0, 3'b000);
    chk({tag, "_lat1"}, {15'd0, out_valid}, 16'd0);
    step();
    chk({tag, "_valid"}, {15'd0, out_valid}, 16'd1);
    chk({tag, "_res"}, {8'd0, result}, {8'd0, er});
    chk({tag, "_flags"}, {12'd0, flags}, {12'd0, ef});
    step();
    chk({tag, "_gone"}, {15'd0, out_valid}, 16'd0);
  endtask

  // Integer-arithmetic reference for WIDTH=4: returns {flags, result}
  function automatic logic [11:0] model(input logic [3:0] va, input logic [3:0] vb, input logic [2:0] s);
    int ai, bi, as_, bs_, r, sr;
    logic [7:0] res;
    logic c, o, n;
    ai  = int'(va);
    bi  = int'(vb);
    as_ = va[3] ? ai - 16 : ai;
    bs_ = vb[3] ? bi - 16 : bi;
    c = 1'b0;
    o = 1'b0;
    res = 8'h00;
    case (s)
      3'd0: begin
        r  = ai + bi;
        sr = as_ + bs_;
        c  = (r > 15);
        o  = (sr > 7) || (sr < -8);
        res = 8'(r % 16);
`ifdef ALU_PIPE_SAT_EN
        if (c) res = 8'h0F;
`endif
      end
      3'd1: begin
        r  = ai - bi + 16;
        sr = as_ - bs_;
        c  = (ai < bi);
        o  = (sr > 7) || (sr < -8);
        res = 8'(r % 16);
`ifdef ALU_PIPE_SAT_EN
        if (c) res = 8'h00;
`endif
      end
      3'd2: res = {4'h0, va & vb};
      3'd3: res = {4'h0, va | vb};
      3'd4: res = 8'(ai * bi);
      3'd5: res = {4'h0, va ^ vb};
      3'd6: res = {4'h0, ~(va & vb)};
      default: res = {4'h0, ~(va | vb)};
    endcase
    n = (s == 3'd4) ? res[7] : res[3];
    return {n, o, c, (res == 8'h00), res};
  endfunction

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 4'h0, 4'h0, 3'b000);
    #12;
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_result", {8'd0, result}, 16'd0);
    chk("rst_flags", {12'd0, flags}, 16'd0);
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    step();
    reset = 1'b0;
    step();

    // Directed single beats
    one_beat("add_9_8",  4'd9,  4'd8,  3'd0, ADD98_R, ADD98_F);
    one_beat("sub_3_5",  4'd3,  4'd5,  3'd1, SUB35_R, SUB35_F);
    one_beat("mul_f_f",  4'd15, 4'd15, 3'd4, 8'hE1, 4'b1000);
    one_beat("mul_0_7",  4'd0,  4'd7,  3'd4, 8'h00, 4'b0001);
    one_beat("add_7_1",  4'd7,  4'd1,  3'd0, 8'h08, 4'b1100);
    one_beat("sub_8_1",  4'd8,  4'd1,  3'd1, 8'h07, 4'b0100);
    one_beat("and_c_a",  4'hC,  4'hA,  3'd2, 8'h08, 4'b1000);
    one_beat("or_3_4",   4'h3,  4'h4,  3'd3, 8'h07, 4'b0000);
    one_beat("xor_5_5",  4'h5,  4'h5,  3'd5, 8'h00, 4'b0001);
    one_beat("nand_f_f", 4'hF,  4'hF,  3'd6, 8'h00, 4'b0001);
    one_beat("nor_c_a",  4'hC,  4'hA,  3'd7, 8'h01, 4'b0000);

    // Backpressure: fill both stages, hold the head, then drain in order
    out_ready = 1'b0;
    drive(1'b1, 4'd1, 4'd1, 3'd0);
    chk("bp_ready0", {15'd0, in_ready}, 16'd1);
    step();
    drive(1'b1, 4'd2, 4'd2, 3'd0);
    chk("bp_ready1", {15'd0, in_ready}, 16'd1);
    step();
    drive(1'b1, 4'd3, 4'd3, 3'd0);
    chk("bp_ready_full", {15'd0, in_ready}, 16'd0);
    chk("bp_head_valid", {15'd0, out_valid}, 16'd1);
    chk("bp_head_res", {8'd0, result}, 16'h02);
    step();
    chk("bp_hold_res1", {8'd0, result}, 16'h02);
    chk("bp_hold_ready1", {15'd0, in_ready}, 16'd0);
    step();
    chk("bp_hold_res2", {8'd0, result}, 16'h02);
    chk("bp_hold_valid2", {15'd0, out_valid}, 16'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", {15'd0, in_ready}, 16'd1);
    step();
    drive(1'b0, 4'h0, 4'h0, 3'b000);
    chk("bp_drain2", {8'd0, result}, 16'h04);
    chk("bp_drain2_v", {15'd0, out_valid}, 16'd1);
    step();
    chk("bp_drain3", {8'd0, result}, 16'h06);
    chk("bp_drain3_v", {15'd0, out_valid}, 16'd1);
    step();
    chk("bp_empty", {15'd0, out_valid}, 16'd0);

    // Streaming: 16 random beats back to back, no backpressure
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        drive(1'b1, 4'($urandom_range(15)), 4'($urandom_range(15)), 3'($urandom_range(7)));
        exp_q.push_back(model(a, b, sel));
        chk("st_in_ready", {15'd0, in_ready}, 16'd1);
      end else begin
        drive(1'b0, 4'h0, 4'h0, 3'b000);
      end
      step();
      if (i >= 1) begin
        exp_beat = exp_q.pop_front();
        chk("st_valid", {15'd0, out_valid}, 16'd1);
        chk("st_res", {8'd0, result}, {8'd0, exp_beat[7:0]});
        chk("st_flags", {12'd0, flags}, {12'd0, exp_beat[11:8]});
      end
    end
    step();
    chk("st_end", {15'd0, out_valid}, 16'd0);

    // Reset with the pipe full: outputs clear without waiting for a clock
    out_ready = 1'b0;
    drive(1'b1, 4'd5, 4'd6, 3'd4);
    step();
    drive(1'b1, 4'd7, 4'd7, 3'd3);
    step();
    drive(1'b0, 4'h0, 4'h0, 3'b000);
    chk("mr_full_valid", {15'd0, out_valid}, 16'd1);
    chk("mr_full_ready", {15'd0, in_ready}, 16'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("mr_out_valid", {15'd0, out_valid}, 16'd0);
    chk("mr_result", {8'd0, result}, 16'd0);
    chk("mr_flags", {12'd0, flags}, 16'd0);
    chk("mr_in_ready", {15'd0, in_ready}, 16'd1);
    step();
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mr_no_stale", {15'd0, out_valid}, 16'd0);
      chk("mr_ready_after", {15'd0, in_ready}, 16'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
